// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcodes, ALU codes, instruction classes and encoder states
package riscv_pkg;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE, CLS_JAL, CLS_JALR
    } instr_class_t;
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} enc_state_t;
endpackage

// File: rtl/instr_format.sv
// instr_format: packs decoded fields into an RV32I word, flagging illegal combos as NOP.
// IMM_RANGE_CHECK_EN adds signed-range and alignment checks on immediates.
module instr_format
    import riscv_pkg::*;
(
    input  instr_class_t cls,
    input  logic [3:0]   alu,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [31:0]  imm,
    output logic [31:0]  word,
    output logic         illegal
);
    logic [2:0]  f3;
    logic [31:0] raw;
    logic        bad_op;
    logic        bad_imm;
    logic        unused_imm;
    assign unused_imm = ^{imm[31:21], imm[0]};
    always_comb begin
        f3 = alu == ALU_AND ? 3'b111 : alu == ALU_OR ? 3'b110 : alu == ALU_SLT ? 3'b010 : 3'b000;
        bad_op = ((cls == CLS_R || cls == CLS_I) && alu > ALU_SLT) || (cls == CLS_I && alu == ALU_SUB);
        raw = NOP_WORD;
        case (cls)
            CLS_R:     raw = {(alu == ALU_SUB) ? 7'b0100000 : 7'b0, rs2, rs1, f3, rd, R_TYPE};
            CLS_I:     raw = {imm[11:0], rs1, f3, rd, I_TYPE};
            CLS_LOAD:  raw = {imm[11:0], rs1, 3'b010, rd, LOAD};
            CLS_STORE: raw = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], STORE};
            CLS_BEQ:   raw = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], BRANCH};
            CLS_BNE:   raw = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], BRANCH};
            CLS_JAL:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
            CLS_JALR:  raw = {imm[11:0], rs1, 3'b000, rd, JALR};
            default:   raw = NOP_WORD;
        endcase
    end
`ifdef IMM_RANGE_CHECK_EN
    logic fits12, fits13, fits21;
    assign fits12 = imm[31:11] == {21{imm[11]}};
    assign fits13 = imm[31:12] == {20{imm[12]}} && !imm[0];
    assign fits21 = imm[31:20] == {12{imm[20]}} && !imm[0];
    assign bad_imm = (cls == CLS_BEQ || cls == CLS_BNE) ? !fits13 :
                     cls == CLS_JAL ? !fits21 :
                     cls == CLS_R ? 1'b0 : !fits12;
`else
    assign bad_imm = 1'b0;
`endif
    assign illegal = bad_op || bad_imm;
    assign word    = illegal ? NOP_WORD : raw;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field bundles over valid/ready and writes encoded RV32I words
// sequentially into instruction memory, one word per two cycles.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256,
    localparam int               CW        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_class,
    input  logic [3:0]        in_alu,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CW-1:0]     count
);
    enc_state_t  state, next;
    logic        last_q;
    logic [31:0] word;
    logic        illegal;
    logic        launch;
    logic        full;
    instr_format u_fmt (
        .cls     (instr_class_t'(in_class)),
        .alu     (in_alu),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (word),
        .illegal (illegal)
    );
    assign launch   = (state == IDLE || state == DONE) && start;
    assign full     = count == CW'(DEPTH - 1);
    assign in_ready = state == ACCEPT;
    assign imem_we  = state == WRITE;
    assign busy     = in_ready || imem_we;
    assign done     = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? ACCEPT : state;
            ACCEPT:     next = in_valid ? WRITE : ACCEPT;
            WRITE:      next = (last_q || full) ? DONE : ACCEPT;
            default:    next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
            last_q     <= 1'b0;
        end else if (launch) begin
            imem_addr <= BASE_ADDR;
            count     <= '0;
            err       <= 1'b0;
        end else if (state == ACCEPT && in_valid) begin
            imem_wdata <= word;
            last_q     <= in_last;
            if (illegal) err <= 1'b1;
        end else if (state == WRITE) begin
            imem_addr <= imem_addr + ADDR_W'(4);
            count     <= count + CW'(1);
            // program ran out of slots before its last instruction
            if (full && !last_q) err <= 1'b1;
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decode path: accepts decoded instruction fields (class, ALU op, registers, immediate) over a valid/ready handshake.
- Packs each instruction into a 32-bit RV32I word.
- Writes words sequentially into instruction memory via a one-cycle write strobe.
- Used by the bench and the boot loader to build programs for the single-cycle core from symbolic fields.

Parameters:
- ADDR_W, 32, width of imem byte address.
- BASE_ADDR, 0, byte address of the first word written after start.
- DEPTH, 256, max words per program; must be ≥1.

Ports:
- clk input 1: single clock.
- rst_n input 1: reset, asynchronous, active-low.
- start input 1: begin new program; sampled only in IDLE.
- in_valid input 1: field bundle valid.
- in_ready output 1: encoder accepts bundle this cycle.
- in_last input 1: bundle is final instruction.
- in_class input 3: R=0, I=1, LOAD=2, STORE=3, BEQ=4, BNE=5, JAL=6, JALR=7.
- in_alu input 4: ADD=0, SUB=1, AND=2, OR=3, SLT=4; used by R and I only.
- in_rd, in_rs1, in_rs2 input 5 each: register indices.
- in_imm input 32: sign-extended immediate/offset.
- imem_we output 1: write strobe.
- imem_addr output ADDR_W: byte address.
- imem_wdata output 32: encoded word.
- busy output 1: not in IDLE/DONE.
- done output 1: program complete.
- err output 1: sticky error.
- count output $clog2(DEPTH)+1: words written.

Behaviour:
- Reset: all outputs 0; imem_addr=BASE_ADDR; FSM=IDLE.
- FSM states:
  - IDLE: start → ACCEPT; addr=BASE_ADDR, count=0, err=0, done=0.
  - ACCEPT: in_ready=1. On in_valid, register the encoded word and the last flag → WRITE.
  - WRITE: in_ready=0, imem_we=1 for exactly one cycle with the registered addr/wdata. Next cycle: addr+=4, count+=1. If last or count+1==DEPTH → DONE, else → ACCEPT.
  - DONE: done=1 held. start → ACCEPT with the IDLE initialisation.
- Throughput: one instruction per 2 cycles. Bundle accept at cycle N gives imem_we at N+1.
- Overflow: if DEPTH words are written without in_last, go to DONE with err=1. Further bundles are not accepted.
- start outside IDLE/DONE: ignored.
- rst_n low mid-operation: immediate return to reset state; a partial write is abandoned (imem_we drops asynchronously).
- Encoding:
  - funct3 by ALU op: ADD/SUB→000, AND→111, OR→110, SLT→010.
  - R: funct7 (0100000 if SUB else 0) | rs2 | rs1 | f3 | rd | 0110011.
  - I: imm[11:0] | rs1 | f3 | rd | 0010011.
  - LOAD: imm[11:0] | rs1 | 010 | rd | 0000011.
  - STORE: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011.
  - BEQ/BNE: imm[12] | imm[10:5] | rs2 | rs1 | 000/001 | imm[4:1] | imm[11] | 1100011.
  - JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111.
  - JALR: imm[11:0] | rs1 | 000 | rd | 1100111.
  - Unused fields are ignored.
- Illegal (in_alu>4, or I with SUB): wdata=0x00000013 (NOP), err=1; slot still written and counted.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: each immediate is range-checked.
  - I/LOAD/STORE/JALR: signed 12-bit.
  - BEQ/BNE: signed 13-bit with imm[0]=0.
  - JAL: signed 21-bit with imm[0]=0.
  - Violation handled as illegal (NOP written, err=1).
- Undefined: immediates silently truncated, no check, err only from illegal ALU/class combos.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JAL, JALR);
  - ALU code localparams (ALU_ADD..ALU_SLT);
  - instr_class_t enum;
  - NOP_WORD constant 0x00000013.
- One combinational sub-module instr_format (fields→word plus illegal flag).
- instr_encoder holds the FSM, address/count registers and error logic.

Test Plan:
- R SUB rd=3 rs1=1 rs2=2, last=1 → one imem_we, addr=0x0, wdata=0x402081B3, done=1, count=1.
- I ADD rd=1 rs1=0 imm=5, then STORE rs2=5 rs1=2 imm=8 last → 0x00500093 @0x0, 0x00512423 @0x4, count=2.
- BEQ rs1=1 rs2=2 imm=-4, then JAL rd=1 imm=8 last → 0xFE208EE3 @0x0, 0x008000EF @0x4.
- I with in_alu=SUB, last → wdata=0x00000013, err=1 sticky until next start.
- DEPTH=4, five bundles, no last → four writes 0x0–0xC, DONE, err=1, fifth bundle never accepted (in_ready=0).
- rst_n asserted during WRITE → imem_we=0 immediately, all outputs zero, addr=BASE_ADDR. The next start rewrites from 0x0.
